// File: rtl/platform_spawn_if.sv
// Platform table bus between the game controller and platform_spawn_ctrl.
// frame_clk_edge is a strobe, not a handshake: 2'b01 for one cycle requests a pass; it is dropped while busy.
interface platform_spawn_if;
    logic [1:0] frame_clk_edge;
    logic [7:0] state;
    logic [3:0] scroll_amt;
    logic [7:0] platform_size;
    logic [9:0] Platform_X_out [0:7];
    logic [9:0] Platform_Y_out [0:7];
    logic       busy;
    logic       done;
    logic [7:0] respawn_count;
    logic [1:0] dbg_state;

    modport master (
        output frame_clk_edge, state, scroll_amt, platform_size,
        input  Platform_X_out, Platform_Y_out, busy, done, respawn_count, dbg_state
    );

    modport slave (
        input  frame_clk_edge, state, scroll_amt, platform_size,
        output Platform_X_out, Platform_Y_out, busy, done, respawn_count, dbg_state
    );
endinterface

// File: rtl/platform_spawn_ctrl.sv
// Per-frame scroll/respawn sequencer for the 8-slot platform table, one slot per cycle.
// Optional PLATFORM_ONE_SPAWN_EN limits each pass to a single respawn; later wraps clamp to the bottom row.
module platform_spawn_ctrl #(
    parameter int W     = 320,
    parameter int H     = 240,
    parameter int X_MIN = 70,
    parameter int X_MAX = 249,
    parameter int N     = 8
) (
    input logic             Clk,
    input logic             Reset,
    platform_spawn_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_t;

    localparam logic [9:0] INIT_X [0:7] = '{10'd140, 10'd180, 10'd220, 10'd160,
                                            10'd70,  10'd140, 10'd80,  10'd120};
    localparam logic [9:0] INIT_Y [0:7] = '{10'd40,  10'd80,  10'd120, 10'd160,
                                            10'd110, 10'd220, 10'd140, 10'd10};

    // The slot arrays and ports are hard-wired to 8 entries of 10 bits.
    if (N != 8 || X_MAX >= W || W > 1024) begin : g_bad_cfg
        $error("platform_spawn_ctrl: unsupported configuration");
    end

    fsm_t       fsm_q;
    logic [2:0] idx_q;
    logic [3:0] amt_q;
    logic [7:0] lfsr_q;
    logic [7:0] count_q;
    logic       busy_q;
    logic       done_q;
    logic [9:0] x_q [0:N-1];
    logic [9:0] y_q [0:N-1];

    logic [9:0] y_new;
    logic       wrap;
    logic [9:0] span;
    logic [9:0] r_raw;
    logic [9:0] r_fix;
    logic [9:0] x_spawn;
    logic [7:0] lfsr_nxt;
    logic       allow_spawn;

`ifdef PLATFORM_ONE_SPAWN_EN
    logic spawned_q;
    assign allow_spawn = ~spawned_q;
`else
    assign allow_spawn = 1'b1;
`endif

    always_comb begin
        y_new    = y_q[idx_q] + {6'd0, amt_q};
        wrap     = y_new > 10'(H - 1);
        span     = 10'(X_MAX - X_MIN + 1) - {2'b00, bus.platform_size};
        r_raw    = {3'b000, lfsr_q[6:0]};
        // A single conditional subtract suffices because span is at least 64.
        r_fix    = (r_raw >= span) ? (r_raw - span) : r_raw;
        x_spawn  = 10'(X_MIN) + r_fix;
        lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsm_q   <= IDLE;
            idx_q   <= 3'd0;
            amt_q   <= 4'd0;
            lfsr_q  <= 8'hA5;
            count_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= INIT_X[k];
                y_q[k] <= INIT_Y[k];
            end
`ifdef PLATFORM_ONE_SPAWN_EN
            spawned_q <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.state == 8'd0) begin
                        for (int k = 0; k < N; k++) begin
                            x_q[k] <= INIT_X[k];
                            y_q[k] <= INIT_Y[k];
                        end
                    end else if (bus.frame_clk_edge == 2'b01) begin
                        amt_q  <= bus.scroll_amt;
                        idx_q  <= 3'd0;
                        busy_q <= 1'b1;
                        fsm_q  <= SCAN;
`ifdef PLATFORM_ONE_SPAWN_EN
                        spawned_q <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (bus.state == 8'd0) begin
                        // Abort: the table returns to its title layout with no done pulse.
                        busy_q <= 1'b0;
                        fsm_q  <= IDLE;
                        for (int k = 0; k < N; k++) begin
                            x_q[k] <= INIT_X[k];
                            y_q[k] <= INIT_Y[k];
                        end
                    end else begin
                        if (wrap && allow_spawn) begin
                            y_q[idx_q] <= 10'd0;
                            x_q[idx_q] <= x_spawn;
                            lfsr_q     <= lfsr_nxt;
                            count_q    <= count_q + 8'd1;
`ifdef PLATFORM_ONE_SPAWN_EN
                            spawned_q  <= 1'b1;
`endif
                        end else if (wrap) begin
                            y_q[idx_q] <= 10'(H - 1);
                        end else begin
                            y_q[idx_q] <= y_new;
                        end
                        if (idx_q == 3'd7) begin
                            done_q <= 1'b1;
                            fsm_q  <= DONE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign bus.Platform_X_out[g] = x_q[g];
        assign bus.Platform_Y_out[g] = y_q[g];
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.respawn_count = count_q;
    assign bus.dbg_state     = fsm_q;
endmodule

// File: tb/tb_platform_spawn_ctrl.sv
// Bench for platform_spawn_ctrl: pass-level reference model compared every cycle, plus literal expectations.
module tb_platform_spawn_ctrl;
    localparam int H     = 240;
    localparam int X_MIN = 70;
    localparam int X_MAX = 249;
`ifdef PLATFORM_ONE_SPAWN_EN
    localparam bit ONE_SPAWN = 1'b1;
`else
    localparam bit ONE_SPAWN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    platform_spawn_if bus ();

    platform_spawn_ctrl dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int init_x [8] = '{140, 180, 220, 160, 70, 140, 80, 120};
    int init_y [8] = '{40, 80, 120, 160, 110, 220, 140, 10};

    // Reference model: pos = -1 idle, 0..7 slot being written this cycle, 8 = done cycle.
    int         mx [8];
    int         my [8];
    bit         m_busy;
    bit         m_done;
    int         m_count;
    logic [7:0] m_lfsr;
    int         pos;
    int         m_amt;
    bit         m_spawned;
    int         m_last;
    int         y_sum;
    int         span;
    int         r;
    logic [9:0] exp_q [$];

    always @(posedge clk) begin
        if (rst) begin
            mx = init_x; my = init_y;
            m_busy = 0; m_done = 0; m_count = 0; m_lfsr = 8'hA5; pos = -1; m_last = 0;
            exp_q.delete();
        end else if (pos < 0) begin
            m_done = 0;
            if (bus.state == 8'd0) begin
                mx = init_x; my = init_y;
            end else if (bus.frame_clk_edge == 2'b01) begin
                m_amt = int'(bus.scroll_amt); pos = 0; m_busy = 1; m_spawned = 0;
            end
        end else if (pos < 8) begin
            if (bus.state == 8'd0) begin
                pos = -1; m_busy = 0; mx = init_x; my = init_y;
            end else begin
                y_sum = my[pos] + m_amt;
                if (y_sum > H - 1 && !(ONE_SPAWN && m_spawned)) begin
                    span = X_MAX - X_MIN - int'(bus.platform_size) + 1;
                    r = int'(m_lfsr) % 128;
                    if (r >= span) r = r - span;
                    my[pos] = 0;
                    mx[pos] = X_MIN + r;
                    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                    m_count = (m_count + 1) % 256;
                    m_spawned = 1;
                    m_last = pos;
                    exp_q.push_back(10'(X_MIN + r));
                end else if (y_sum > H - 1) begin
                    my[pos] = H - 1;
                end else begin
                    my[pos] = y_sum;
                end
                pos++;
                if (pos == 8) m_done = 1;
            end
        end else begin
            m_done = 0; m_busy = 0; pos = -1;
        end
    end

    // Compare process: every cycle out of reset, just after the DUT registers settle.
    logic [7:0] prev_cnt;
    logic [9:0] e_x;
    int         bad;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_cnt = 8'd0;
        end else begin
            bad = -1;
            for (int k = 0; k < 8; k++) begin
                if (bad < 0 && (bus.Platform_X_out[k] !== 10'(mx[k]) || bus.Platform_Y_out[k] !== 10'(my[k])))
                    bad = k;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL table slot %0d got X=%0d Y=%0d expected X=%0d Y=%0d at %0t",
                         bad, bus.Platform_X_out[bad], bus.Platform_Y_out[bad], mx[bad], my[bad], $time);
            end
            checks++;
            if (bus.busy !== m_busy || bus.done !== m_done) begin
                errors++;
                $display("FAIL busy_done got %b%b expected %b%b at %0t", bus.busy, bus.done, m_busy, m_done, $time);
            end
            checks++;
            if (bus.respawn_count !== 8'(m_count)) begin
                errors++;
                $display("FAIL respawn_count got %0d expected %0d at %0t", bus.respawn_count, m_count, $time);
            end
            if (bus.respawn_count !== prev_cnt) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL respawn_x unexpected respawn, count got %0d expected %0d", bus.respawn_count, prev_cnt);
                end else begin
                    e_x = exp_q.pop_front();
                    if (bus.Platform_X_out[m_last] !== e_x) begin
                        errors++;
                        $display("FAIL respawn_x slot %0d got %0d expected %0d", m_last, bus.Platform_X_out[m_last], e_x);
                    end
                end
                prev_cnt = bus.respawn_count;
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame edge, then a fixed 12-cycle observation window; lat counts cycles after the sample cycle.
    task automatic run_pass(input int amt, input int edge_at, input int abort_at,
                            output int dcnt, output int dlat);
        int lat;
        dcnt = 0;
        dlat = 0;
        @(negedge clk);
        bus.frame_clk_edge = 2'b01;
        bus.scroll_amt     = amt[3:0];
        @(negedge clk);
        bus.frame_clk_edge = 2'b00;
        lat = 1;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            bus.frame_clk_edge = (lat == edge_at) ? 2'b01 : 2'b00;
            if (lat == abort_at) bus.state = 8'd0;
            else if (lat == abort_at + 1) bus.state = 8'd1;
            if (bus.done === 1'b1) begin
                dcnt++;
                if (dlat == 0) dlat = lat;
            end
        end
        bus.frame_clk_edge = 2'b00;
        bus.state = 8'd1;
    endtask

    task automatic stray_edge(input logic [1:0] v);
        @(negedge clk);
        bus.frame_clk_edge = v;
        @(negedge clk);
        bus.frame_clk_edge = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    int dc;
    int dl;
    int amts  [12] = '{15, 15, 0, 12, 15, 9, 15, 15, 14, 15, 15, 13};
    int sizes [4]  = '{60, 100, 116, 52};

    initial begin
        bus.frame_clk_edge = 2'b00;
        bus.state          = 8'd1;
        bus.scroll_amt     = 4'd0;
        bus.platform_size  = 8'd60;

        do_reset();
        repeat (3) @(negedge clk);
        lit("reset slot0 Y", int'(bus.Platform_Y_out[0]), 40);
        lit("reset slot7 X", int'(bus.Platform_X_out[7]), 120);
        lit("reset busy", int'(bus.busy), 0);
        lit("reset respawn_count", int'(bus.respawn_count), 0);

        run_pass(5, 0, 0, dc, dl);
        lit("scroll5 done latency", dl, 9);
        lit("scroll5 done pulses", dc, 1);
        lit("scroll5 slot0 Y", int'(bus.Platform_Y_out[0]), 45);
        lit("scroll5 slot7 Y", int'(bus.Platform_Y_out[7]), 15);

        do_reset();
        run_pass(15, 0, 0, dc, dl);
        lit("scroll15 slot5 Y", int'(bus.Platform_Y_out[5]), 235);
        run_pass(15, 0, 0, dc, dl);
        lit("respawn slot5 Y", int'(bus.Platform_Y_out[5]), 0);
        lit("respawn slot5 X", int'(bus.Platform_X_out[5]), 107);
        lit("respawn count", int'(bus.respawn_count), 1);

        run_pass(3, 3, 0, dc, dl);
        lit("edge in scan done pulses", dc, 1);
        lit("edge in scan slot0 Y", int'(bus.Platform_Y_out[0]), 73);
        lit("edge in scan slot5 Y", int'(bus.Platform_Y_out[5]), 3);

        run_pass(7, 0, 3, dc, dl);
        lit("abort done pulses", dc, 0);
        lit("abort slot0 Y", int'(bus.Platform_Y_out[0]), 40);
        lit("abort slot5 X", int'(bus.Platform_X_out[5]), 140);
        lit("abort busy", int'(bus.busy), 0);

        for (int i = 0; i < 12; i++) begin
            bus.platform_size = 8'(sizes[i % 4]);
            if (i == 2) stray_edge(2'b11);
            if (i == 5) stray_edge(2'b10);
            run_pass(amts[i], 0, 0, dc, dl);
            lit("sweep done pulses", dc, 1);
        end
        lit("sweep respawn_count matches model", int'(bus.respawn_count), m_count);

        repeat (3) @(negedge clk);
        lit("respawn queue drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
